uart_frame_synch: RTL
=====================

// Module: uart_frame_synch
// PURPOSE
//  Successor to the two-flop UART control synchroniser. Takes the UART receiver's byte stream
//  (toggle-strobe + data) into the system clock domain through a SYNC_STAGES synchroniser, then
//  parses command frames (classify / train + label) into a parametrised image buffer.
//  Issues a single-cycle start/train pulse with a stable image to the network core.
//  Sits between uart_rx and the NN core; replaces the raw start/train/image synchroniser.
// PARAMETERS
//  IMG_BYTES    784       pixel bytes per frame; image width = IMG_BYTES*8
//  SYNC_STAGES  2         flops in the rx_toggle synchroniser chain; legal >= 2
//  TIMEOUT_CYC  1000000   clk cycles of inter-byte silence that abort a frame; 0 disables
//  CMD_START    8'h53     command byte: classify frame
//  CMD_TRAIN    8'h54     command byte: train frame (followed by one label byte)
// PORTS
//  clk          in   1              system clock
//  rst          in   1              asynchronous reset, active-high
//  rx_toggle    in   1              async; inverts once per new UART byte
//  rx_data      in   8              async; stable from before rx_toggle flips until its next flip
//  core_ready   in   1              NN core can accept a frame this cycle
//  start_out    out  1              1-cycle pulse: classify image_out
//  train_out    out  1              1-cycle pulse: train on image_out with label_out
//  label_out    out  8              label of last issued train frame
//  image_out    out  IMG_BYTES*8    last issued image; byte i at [8i+7:8i]
//  busy         out  1              frame in progress or awaiting issue (state != IDLE)
//  frame_err    out  1              1-cycle pulse: bad command byte or timeout abort
//  overrun_err  out  1              1-cycle pulse: byte dropped while in ISSUE
// BEHAVIOUR
//  Reset: all outputs 0, sync chain and edge-detect flop 0, state IDLE, counters 0.
//  rx_toggle at reset release must equal 0; if 1, exactly one byte event follows (defined).
//  Byte event: byte_evt = sync[SYNC_STAGES-1] ^ prev; one cycle per rx_toggle flip; rx_data
//   captured with a plain register on that cycle. Flip to byte_evt: SYNC_STAGES clk edges.
//  FSM (acts only on byte_evt except ISSUE/timeout):
//   IDLE:   CMD_START -> PIXELS (mode=classify); CMD_TRAIN -> LABEL (mode=train);
//           any other byte -> frame_err pulse, stay IDLE.
//   LABEL:  byte -> label buffer, -> PIXELS.
//   PIXELS: byte k (k=0..IMG_BYTES-1) -> internal buffer bits [8k+7:8k]; pix_cnt++;
//           byte IMG_BYTES-1 -> ISSUE, pix_cnt cleared.
//   ISSUE:  on the first clk edge with core_ready=1: image_out<=buffer, label_out<=label buffer
//           (train only), start_out or train_out <=1 for that next cycle only; -> IDLE.
//           byte_evt while in ISSUE: byte dropped, overrun_err pulse; byte_evt on the issuing
//           edge itself also dropped.
//  image_out/label_out change only on the issuing edge; stable between frames.
//  Timeout (TIMEOUT_CYC>0): idle counter runs in LABEL/PIXELS, cleared on every byte_evt and on
//   entering LABEL/PIXELS; reaching TIMEOUT_CYC -> IDLE, frame_err pulse, pix_cnt cleared.
//   byte_evt and timeout same cycle: byte wins, counter clears. No timeout in ISSUE.
//  Counters sized $clog2(IMG_BYTES+1) and $clog2(TIMEOUT_CYC+1); no wrap in legal operation.
//  Reset mid-frame: immediate abort, everything to reset values, no pulse emitted.
// TESTING
//  1 CMD_START + bytes 0..783 (value=i%256), core_ready=1 -> one start_out pulse, image_out
//    byte i == i%256, busy falls same cycle start_out rises, train_out stays 0.
//  2 CMD_TRAIN, label 8'h07, 784 bytes of 8'hAA, core_ready=0 for 50 cycles then 1 -> busy high
//    throughout, train_out pulse 1 cycle after core_ready rises, label_out=8'h07.
//  3 First byte 8'h41 -> frame_err 1-cycle pulse, state IDLE; next valid frame issues correctly.
//  4 TIMEOUT_CYC=100: CMD_START + 10 bytes, then silence -> frame_err pulse exactly 100 cycles
//    after last byte_evt, busy 0; new full frame afterwards issues with correct image.
//  5 Byte sent during ISSUE (core_ready=0) -> overrun_err pulse, image_out unchanged on issue.
//  6 rst asserted mid-PIXELS -> all outputs 0 asynchronously; no start/train pulse after release.

Source files
------------

// File: rtl/uart_frame_synch.sv
// UART byte-stream synchroniser and command-frame parser feeding the NN core.
// Brings the rx_toggle/rx_data pair into the clk domain and assembles
// classify (CMD_START) and train (CMD_TRAIN + label) frames of IMG_BYTES
// pixels, then issues one start/train pulse with a stable image.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   rx_toggle    async, inverts once per received UART byte
//   rx_data      async, byte that accompanies the latest rx_toggle flip
//   core_ready   NN core accepts a frame on this clock edge
//   start_out    1-cycle pulse: classify image_out
//   train_out    1-cycle pulse: train on image_out with label_out
//   label_out    label of the last issued train frame
//   image_out    last issued image, byte i at [8i+7:8i]
//   busy         frame being received or waiting to be issued
//   frame_err    1-cycle pulse: bad command byte or inter-byte timeout
//   overrun_err  1-cycle pulse: byte dropped while waiting to issue
module uart_frame_synch #(
  parameter int unsigned IMG_BYTES   = 784,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  CMD_START   = 8'h53,
  parameter logic [7:0]  CMD_TRAIN   = 8'h54
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_toggle,
  input  logic [7:0]             rx_data,
  input  logic                   core_ready,
  output logic                   start_out,
  output logic                   train_out,
  output logic [7:0]             label_out,
  output logic [IMG_BYTES*8-1:0] image_out,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun_err
);

  localparam int unsigned IW = IMG_BYTES * 8;
  localparam int unsigned PW = $clog2(IMG_BYTES + 1);
  localparam int unsigned TW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [PW-1:0] PIX_LAST = PW'(IMG_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LABEL,
    S_PIXELS,
    S_ISSUE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   byte_evt;
  logic                   to_hit;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [PW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [TW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [IW-1:0]          img_buf_q, img_buf_d;
  logic [IW-1:0]          image_q, image_d;
  logic [7:0]             lbl_buf_q, lbl_buf_d;
  logic [7:0]             label_q, label_d;
  logic                   start_q, start_d;
  logic                   train_q, train_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  // Toggle synchroniser; one byte_evt per rx_toggle flip.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_toggle};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign byte_evt = sync_q[SYNC_STAGES-1] ^ prev_q;

  // Counter has seen TIMEOUT_CYC-1 silent cycles; this edge is the last.
  assign to_hit = TO_EN && (idle_cnt_q == TO_LAST);

  // rx_data is held stable across the whole synchroniser delay, so it is
  // safe to sample directly on the byte_evt cycle.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pix_cnt_d  = pix_cnt_q;
    idle_cnt_d = idle_cnt_q;
    img_buf_d  = img_buf_q;
    image_d    = image_q;
    lbl_buf_d  = lbl_buf_q;
    label_d    = label_q;
    start_d    = 1'b0;
    train_d    = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (byte_evt) begin
          if (rx_data == CMD_START) begin
            state_d   = S_PIXELS;
            mode_d    = 1'b0;
            pix_cnt_d = '0;
          end else if (rx_data == CMD_TRAIN) begin
            state_d   = S_LABEL;
            mode_d    = 1'b1;
            pix_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      S_LABEL: begin
        if (byte_evt) begin
          lbl_buf_d  = rx_data;
          state_d    = S_PIXELS;
          idle_cnt_d = '0;
        end else if (to_hit) begin
          state_d    = S_IDLE;
          ferr_d     = 1'b1;
          pix_cnt_d  = '0;
          idle_cnt_d = '0;
        end else if (TO_EN) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end

      S_PIXELS: begin
        if (byte_evt) begin
          img_buf_d[{pix_cnt_q, 3'b000} +: 8] = rx_data;
          idle_cnt_d = '0;
          if (pix_cnt_q == PIX_LAST) begin
            state_d   = S_ISSUE;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end else if (to_hit) begin
          state_d    = S_IDLE;
          ferr_d     = 1'b1;
          pix_cnt_d  = '0;
          idle_cnt_d = '0;
        end else if (TO_EN) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end

      S_ISSUE: begin
        idle_cnt_d = '0;
        // Nothing is parsed until the frame has left; even a byte on the
        // issuing edge is dropped rather than taken as a command.
        if (byte_evt) begin
          ovr_d = 1'b1;
        end
        if (core_ready) begin
          image_d = img_buf_q;
          state_d = S_IDLE;
          if (mode_q) begin
            label_d = lbl_buf_q;
            train_d = 1'b1;
          end else begin
            start_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      pix_cnt_q  <= '0;
      idle_cnt_q <= '0;
      img_buf_q  <= '0;
      image_q    <= '0;
      lbl_buf_q  <= '0;
      label_q    <= '0;
      start_q    <= 1'b0;
      train_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      pix_cnt_q  <= pix_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      img_buf_q  <= img_buf_d;
      image_q    <= image_d;
      lbl_buf_q  <= lbl_buf_d;
      label_q    <= label_d;
      start_q    <= start_d;
      train_q    <= train_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign start_out   = start_q;
  assign train_out   = train_q;
  assign label_out   = label_q;
  assign image_out   = image_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

endmodule
